// File: rtl/base3_pkg.sv
// Shared definitions for the base-3 counter: digit codes, converter states and helpers.
package base3_pkg;

    localparam logic [1:0] CIFRA_0 = 2'b00;
    localparam logic [1:0] CIFRA_1 = 2'b01;
    localparam logic [1:0] CIFRA_2 = 2'b10;

    typedef enum logic [1:0] {
        S_ATTESA_SOC  = 2'b00,
        S_CONV        = 2'b01,
        S_ATTESA_FINE = 2'b10
    } stato_t;

    // True when a w_bin-bit result can hold every value of an n_cifre-digit count.
    function automatic bit w_bin_ok(int unsigned n_cifre, int unsigned w_bin);
        longint unsigned p3;
        p3 = 1;
        for (int unsigned i = 0; i < n_cifre; i++) begin
            p3 = p3 * 3;
        end
        return (w_bin >= 63) || ((64'd1 << w_bin) >= p3);
    endfunction

    function automatic logic [1:0] valore_cifra(logic [1:0] c);
        return (c == 2'b11) ? CIFRA_0 : c;
    endfunction

endpackage

// File: rtl/contatore_base_3_convertitore_if.sv
// Counter control, digit outputs and soc/eoc conversion handshake of the base-3 counter.
interface contatore_base_3_convertitore_if #(
    parameter int unsigned N_CIFRE = 4,
    parameter int unsigned W_BIN   = 7
);
    logic                   ei;
    logic                   clr;
    logic                   eu;
    logic [2*N_CIFRE-1:0]   cifre;
    logic                   soc;
    logic                   eoc;
    logic [W_BIN-1:0]       bin;

    modport master (
        output ei, clr, soc,
        input  eu, cifre, eoc, bin
    );

    modport slave (
        input  ei, clr, soc,
        output eu, cifre, eoc, bin
    );
endinterface

// File: rtl/cifra_base_3.sv
// Single base-3 digit: 2-bit register with synchronous clear and carry in/out.
module cifra_base_3
    import base3_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       ei,
    output logic       eu,
    output logic [1:0] q1_q0
);

    logic [1:0] r_q;
    logic [1:0] w_q_next;

    always_comb begin
        w_q_next = r_q;
        if (clr) begin
            w_q_next = CIFRA_0;
        end else if (ei) begin
            case (r_q)
                CIFRA_0: w_q_next = CIFRA_1;
                CIFRA_1: w_q_next = CIFRA_2;
                default: w_q_next = CIFRA_0; // 2 wraps, illegal 2'b11 recovers to 0
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= CIFRA_0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign eu    = ei & (r_q == CIFRA_2) & ~clr;
    assign q1_q0 = r_q;

endmodule

// File: rtl/contatore_base_3_convertitore.sv
// N-digit base-3 ripple counter with a sequential ternary-to-binary converter
// driven by a soc/eoc handshake on a snapshot of the count.
module contatore_base_3_convertitore
    import base3_pkg::*;
#(
    parameter int unsigned N_CIFRE = 4,
    parameter int unsigned W_BIN   = 7
) (
    input  logic                            clock,
    input  logic                            reset,
    contatore_base_3_convertitore_if.slave  bus
);

    localparam int unsigned W_K = (N_CIFRE > 1) ? $clog2(N_CIFRE) : 1;

    if (!w_bin_ok(N_CIFRE, W_BIN)) begin : g_w_bin_check
        $error("W_BIN too small for N_CIFRE base-3 digits");
    end

    logic [N_CIFRE:0]       w_carry;
    logic [2*N_CIFRE-1:0]   w_cifre;

    assign w_carry[0] = bus.ei;

    for (genvar g = 0; g < N_CIFRE; g++) begin : g_cifre
        cifra_base_3 u_cifra (
            .clock (clock),
            .reset (reset),
            .clr   (bus.clr),
            .ei    (w_carry[g]),
            .eu    (w_carry[g+1]),
            .q1_q0 (w_cifre[2*g+1:2*g])
        );
    end

    assign bus.eu    = w_carry[N_CIFRE];
    assign bus.cifre = w_cifre;

    stato_t                 r_stato, w_stato_next;
    logic [2*N_CIFRE-1:0]   r_snap, w_snap_next;
    logic [W_BIN-1:0]       r_acc, w_acc_next;
    logic [W_BIN-1:0]       r_bin, w_bin_next;
    logic [W_K-1:0]         r_k, w_k_next;
    logic [1:0]             w_cifra;
    logic [W_BIN-1:0]       w_acc_calc;

    // Horner step: MSB digit first, acc = acc*3 + digit[k].
    assign w_cifra    = valore_cifra(2'(r_snap >> {r_k, 1'b0}));
    assign w_acc_calc = (r_acc << 1) + r_acc + W_BIN'(w_cifra);

    always_comb begin
        w_stato_next = r_stato;
        w_snap_next  = r_snap;
        w_acc_next   = r_acc;
        w_bin_next   = r_bin;
        w_k_next     = r_k;
        case (r_stato)
            S_ATTESA_SOC: begin
                if (bus.soc) begin
                    w_snap_next  = w_cifre;
                    w_acc_next   = '0;
                    w_k_next     = W_K'(N_CIFRE - 1);
                    w_stato_next = S_CONV;
                end
            end
            S_CONV: begin
                w_acc_next = w_acc_calc;
                w_k_next   = r_k - 1'b1;
                if (r_k == '0) begin
                    w_bin_next   = w_acc_calc;
                    w_stato_next = S_ATTESA_FINE;
                end
            end
            S_ATTESA_FINE: begin
                if (!bus.soc) begin
                    w_stato_next = S_ATTESA_SOC;
                end
            end
            default: w_stato_next = S_ATTESA_SOC;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stato <= S_ATTESA_SOC;
            r_snap  <= '0;
            r_acc   <= '0;
            r_bin   <= '0;
            r_k     <= '0;
        end else begin
            r_stato <= w_stato_next;
            r_snap  <= w_snap_next;
            r_acc   <= w_acc_next;
            r_bin   <= w_bin_next;
            r_k     <= w_k_next;
        end
    end

    assign bus.eoc = (r_stato == S_ATTESA_SOC);
    assign bus.bin = r_bin;

endmodule

// File: tb/tb_contatore_base_3_convertitore.sv
// Self-checking bench: integer reference model of the counter and converter, directed and random stimulus.
module tb_contatore_base_3_convertitore;

    localparam int unsigned N      = 4;
    localparam int unsigned W      = 7;
    localparam int          MODULO = 81;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    contatore_base_3_convertitore_if #(.N_CIFRE(N), .W_BIN(W)) bus ();

    contatore_base_3_convertitore #(
        .N_CIFRE (N),
        .W_BIN   (W)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: count as an integer, converter as "idle / edges left / waiting for soc low".
    int m_count, m_bin, m_snap, m_left;
    bit m_idle;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [2*N-1:0] c);
        int v = 0;
        for (int i = N - 1; i >= 0; i--) begin
            v = v * 3 + int'(c[2*i +: 2]);
        end
        return v;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_bin   = 0;
        m_snap  = 0;
        m_left  = 0;
        m_idle  = 1'b1;
    endtask

    task automatic model_edge();
        if (m_idle) begin
            if (bus.soc) begin
                m_snap = m_count;
                m_left = N;
                m_idle = 1'b0;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_bin = m_snap;
        end else if (!bus.soc) begin
            m_idle = 1'b1;
        end
        if (bus.clr)     m_count = 0;
        else if (bus.ei) m_count = (m_count + 1) % MODULO;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "/cifre"}, decode(bus.cifre), m_count);
        check_eq({tag, "/eoc"}, int'(bus.eoc), int'(m_idle));
        check_eq({tag, "/bin"}, int'(bus.bin), m_bin);
    endtask

    task automatic step(input string tag);
        #1;
        check_eq({tag, "/eu"}, int'(bus.eu),
                 int'(bus.ei && (m_count == MODULO - 1) && !bus.clr));
        @(posedge clock);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic count_to(input int target);
        bus.ei = 1'b1;
        while (m_count != target) step("goto");
        bus.ei = 1'b0;
    endtask

    task automatic reset_pulse(input string tag);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs(tag);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        bus.ei  = 1'b0;
        bus.clr = 1'b0;
        bus.soc = 1'b0;
        model_reset();
        #2;
        check_outputs("por");
        #1;
        reset = 1'b0;

        // 1: build non-zero count and bin, then async reset between edges
        count_to(20);
        bus.soc = 1'b1;
        step("conv20");
        bus.soc = 1'b0;
        repeat (6) step("conv20");
        check_eq("bin_20", int'(bus.bin), 20);
        reset_pulse("rst_mid");

        // 2: full wrap over 81 edges
        bus.ei = 1'b1;
        for (int i = 0; i < MODULO; i++) step("wrap");
        bus.ei = 1'b0;
        check_eq("wrap_zero", decode(bus.cifre), 0);

        // 3: clr beats ei at 1021
        count_to(34);
        bus.ei  = 1'b1;
        bus.clr = 1'b1;
        step("clr_wins");
        bus.clr = 1'b0;
        bus.ei  = 1'b0;

        // 4: convert 1021 with the counter still moving
        count_to(34);
        bus.soc = 1'b1;
        step("conv1021");
        bus.soc = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.ei = 1'($urandom_range(0, 1));
            step("conv1021");
        end
        bus.ei = 1'b0;
        check_eq("bin_1021", int'(bus.bin), 34);

        // 5: soc held high across many edges after a 2222 snapshot
        count_to(80);
        bus.soc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.ei = 1'($urandom_range(0, 1));
            step("soc_held");
        end
        check_eq("held_eoc", int'(bus.eoc), 0);
        check_eq("held_bin", int'(bus.bin), 80);
        bus.soc = 1'b0;
        bus.ei  = 1'b0;
        step("soc_drop");
        check_eq("drop_eoc", int'(bus.eoc), 1);

        // 6: reset during the second conversion cycle, then a clean conversion of 0
        count_to(50);
        bus.soc = 1'b1;
        step("abort");
        bus.soc = 1'b0;
        reset_pulse("abort_rst");
        check_eq("abort_bin", int'(bus.bin), 0);
        bus.soc = 1'b1;
        step("conv0");
        bus.soc = 1'b0;
        repeat (6) step("conv0");
        check_eq("bin_0", int'(bus.bin), 0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            bus.ei  = ($urandom_range(0, 3) != 0);
            bus.clr = ($urandom_range(0, 15) == 0);
            bus.soc = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
